// File: rtl/mem_wb_multi.sv
// MEM->WB stage register with NUM_WB qualified write lanes, optional HI/LO bundle and stall-profiling counters.
// Define MEM_WB_HILO_EN to build the HI/LO registers; otherwise wb_hi/wb_lo/wb_whilo are tied to zero.
module mem_wb_multi #(
    parameter int NUM_WB    = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STALL_W-1:0]         stall,
    input  logic                       flush,
    input  logic                       mem_valid,
    input  logic [NUM_WB*ADDR_W-1:0]   mem_wd,
    input  logic [NUM_WB-1:0]          mem_wreg,
    input  logic [NUM_WB*DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]          mem_hi,
    input  logic [DATA_W-1:0]          mem_lo,
    input  logic                       mem_whilo,
    output logic                       wb_valid,
    output logic [NUM_WB*ADDR_W-1:0]   wb_wd,
    output logic [NUM_WB-1:0]          wb_wreg,
    output logic [NUM_WB*DATA_W-1:0]   wb_wdata,
    output logic [DATA_W-1:0]          wb_hi,
    output logic [DATA_W-1:0]          wb_lo,
    output logic                       wb_whilo,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           hold_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_CLEAR
    } action_e;

    action_e             action;
    logic [NUM_WB-1:0]   qual_wreg;
    logic                unused_stall;

    // Only this stage's bit and the downstream bit matter here.
    assign unused_stall = ^stall;

    always_comb begin
        if (flush)
            action = ACT_CLEAR;
        else if (!stall[STAGE_IDX])
            action = ACT_ADVANCE;
        else if (stall[STAGE_IDX+1])
            action = ACT_HOLD;
        else
            action = ACT_BUBBLE;
    end

    // Lanes die on an invalid slot, on register 0, or when a higher lane targets the same address.
    // NOTE: combinational blocks use blocking '=' with a default assigned first, so no latch is inferred.
    always_comb begin
        qual_wreg = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            qual_wreg[i] = mem_valid & mem_wreg[i] & (mem_wd[i*ADDR_W +: ADDR_W] != '0);
            for (int j = i + 1; j < NUM_WB; j++) begin
                if (mem_wreg[j] && (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W]))
                    qual_wreg[i] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || action == ACT_CLEAR || action == ACT_BUBBLE) begin
            wb_valid <= 1'b0;
            wb_wd    <= '0;
            wb_wreg  <= '0;
            wb_wdata <= '0;
        end else if (action == ACT_ADVANCE) begin
            wb_valid <= mem_valid;
            wb_wd    <= mem_wd;
            wb_wreg  <= qual_wreg;
            wb_wdata <= mem_wdata;
        end
    end

    // Flush suppresses both counters because it takes priority over the stall decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (action == ACT_BUBBLE) begin
            if (bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_ONE;
        end else if (action == ACT_HOLD) begin
            if (hold_cnt != CNT_MAX)
                hold_cnt <= hold_cnt + CNT_ONE;
        end
    end

`ifdef MEM_WB_HILO_EN
    always_ff @(posedge clk) begin
        if (rst || action == ACT_CLEAR || action == ACT_BUBBLE) begin
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_whilo <= 1'b0;
        end else if (action == ACT_ADVANCE) begin
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
            wb_whilo <= mem_whilo & mem_valid;
        end
    end
`else
    logic unused_hilo;

    assign unused_hilo = ^{mem_hi, mem_lo, mem_whilo};
    assign wb_hi       = '0;
    assign wb_lo       = '0;
    assign wb_whilo    = 1'b0;
`endif

endmodule

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
- Parametrised MEM→WB pipeline register for the pipelined CPU, successor to the single-port stage register.
- Carries NUM_WB independent register-file write lanes plus the HI/LO bundle.
- Adds a valid bit, an explicit flush, squashing of writes to register 0, and same-address write arbitration between lanes.
- Adds saturating bubble and hold counters for stall profiling.
- Sits between the memory stage and the register file / HI-LO unit; feeds the forwarding network.

Parameters:
- NUM_WB, 2: number of register-file write lanes (1..4).
- DATA_W, 32: data width of each write lane and of HI/LO.
- ADDR_W, 5: register address width.
- STALL_W, 6: width of the global stall vector.
- STAGE_IDX, 4: index of this stage in the stall vector; requires STAGE_IDX+1 < STALL_W.
- CNT_W, 16: width of the profiling counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  global stall vector from the stall controller.
- flush  in  1  squashes this stage's contents (exception/redirect).
- mem_valid  in  1  memory-stage slot holds a real instruction.
- mem_wd  in  NUM_WB*ADDR_W  destination address per lane; lane i in bits [i*ADDR_W +: ADDR_W].
- mem_wreg  in  NUM_WB  write enable per lane.
- mem_wdata  in  NUM_WB*DATA_W  write data per lane.
- mem_hi, mem_lo  in  DATA_W each  HI/LO write values.
- mem_whilo  in  1  HI/LO write enable.
- wb_valid  out  1  registered valid.
- wb_wd  out  NUM_WB*ADDR_W  registered addresses.
- wb_wreg  out  NUM_WB  registered, qualified write enables.
- wb_wdata  out  NUM_WB*DATA_W  registered data.
- wb_hi, wb_lo  out  DATA_W each  registered HI/LO values.
- wb_whilo  out  1  registered HI/LO write enable.
- bubble_cnt  out  CNT_W  number of bubbles inserted.
- hold_cnt  out  CNT_W  number of held cycles.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Registered outputs: all wb_* are flops.
- Latency: 1 cycle from mem_* to wb_* when advancing.
- Per-edge priority, highest first:
  1. rst: every wb_* output is 0 (valid, enables, addresses, data, HI/LO). bubble_cnt = 0, hold_cnt = 0.
  2. flush: all wb_* outputs are cleared as for reset. Counters are unchanged.
  3. Bubble, when stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0: all wb_* outputs are cleared. bubble_cnt increments.
  4. Hold, when stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1: all wb_* outputs keep their values. hold_cnt increments.
  5. Advance, when stall[STAGE_IDX]=0: load the inputs.
     - wb_valid <= mem_valid.
     - Addresses and data are copied unconditionally.
     - Enables are qualified as below.
- Enable qualification on advance, applied combinationally to the inputs before the flop:
  - A lane is killed if mem_valid=0.
  - A lane is killed if its mem_wd = 0; register 0 is never written.
  - Same-address conflict: if lanes i<j both have enables set with equal addresses, lane i is killed; the highest-index lane wins.
  - wb_whilo <= mem_whilo & mem_valid.
- Counters saturate at all-ones and never wrap.
- Simultaneous flush and stall: flush wins, and no counter increments.
- Reset mid-hold: the reset values take effect on that edge. The stage resumes in the advance/bubble state next cycle according to stall.
- There is no other internal state; behaviour is fully determined by the inputs on each edge.

Optional Feature:
- Macro: MEM_WB_HILO_EN.
- Defined: HI/LO ports and registers exist as described above.
- Not defined:
  - The mem_hi, mem_lo and mem_whilo inputs are ignored.
  - wb_hi and wb_lo are tied to 0 and wb_whilo is tied to 0.
  - No HI/LO flops are synthesised; port list unchanged.

Test Plan:
1. Reset and advance: rst=1 for 2 cycles, then advance with lane0 (wd=3, wreg=1, wdata=0xDEADBEEF) and lane1 (wd=7, wreg=1, wdata=0x12345678), mem_valid=1 → one cycle later wb_* equal the inputs, wb_wreg=2'b11, wb_valid=1.
2. Bubble: stall=6'b010000 with inputs as in test 1 → all wb_* are 0 next cycle, bubble_cnt=1. Repeat for 3 cycles → bubble_cnt=3.
3. Hold: load the test 1 values, then stall=6'b110000 for 4 cycles with changed inputs → wb_* stay at the test 1 values, hold_cnt=4.
4. Write qualification:
   - lane0 wd=0, wreg=1 → wb_wreg[0]=0.
   - lane0 and lane1 both wd=9, wreg=1 → wb_wreg=2'b10, wb_wdata lane1 = lane1 input.
   - mem_valid=0 with wreg=2'b11 and whilo=1 → wb_wreg=0, wb_whilo=0.
5. Flush priority: flush=1 with stall=6'b010000 → wb_* cleared, bubble_cnt unchanged. Separately, rst asserted during a hold → all outputs and counters are 0 next edge.
6. Saturation and macro: with CNT_W=4, 20 bubble cycles → bubble_cnt=4'hF. With MEM_WB_HILO_EN undefined, mem_whilo=1, mem_hi=0xAAAA5555 → wb_hi=0 and wb_whilo=0.
